alu_iterative: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller.

---
 rtl/alu_iterative_if.sv | 40 ++++
 rtl/alu_iterative.sv | 179 +++++++++++++++++
 tb/tb_alu_iterative.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iterative_if.sv
// Handshake bundle between the ALU controller / operand fetch and the
// iterative execute-stage ALU. The master side issues operations and takes
// results; the slave side is the ALU itself.
interface alu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid,
        output operation,
        output src_a,
        output src_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  operation,
        input  src_a,
        input  src_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output zero
    );
endinterface

// File: rtl/alu_iterative.sv
// Execute-stage ALU. Logic/arithmetic/compare ops finish in one cycle;
// shifts run through a one-bit-per-cycle serial shifter. The result and its
// zero flag are held under a valid/ready handshake until taken.
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_iterative_if.slave bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic             accept;
    logic             finish_shift;
    logic             release_out;
    logic             go_shift;

    logic [3:0]       op_r;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_now;
    logic [WIDTH-1:0] shift_nxt;

    // True for the three serial-shifter opcodes.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Single-cycle result. Shift ops only land here with a zero shift
    // amount, where the answer is simply src_a.
    function automatic logic [WIDTH-1:0] alu_one_cycle(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH-1:0]        r;
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        case (op)
            OP_AND:                 r = a & b;
            OP_OR:                  r = a | b;
            OP_ADD:                 r = a + b;
            OP_SLL, OP_SRL, OP_SRA: r = a;
            OP_EQ:                  r = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:                 r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default:                r = '0;
        endcase
        return r;
    endfunction

    // One step of the serial shifter in the direction selected by op.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] v
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign shamt     = bus.src_b[SHW-1:0];
    assign alu_now   = alu_one_cycle(bus.operation, bus.src_a, bus.src_b);
    assign shift_nxt = shift_one(op_r, shreg);
    assign go_shift  = is_shift(bus.operation) && (shamt != '0);

    // in_ready stays low while reset is held and rises only after the first
    // clock edge that follows release, so arm on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        finish_shift = 1'b0;
        release_out  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = go_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (count == SHW'(1)) begin
                    finish_shift = 1'b1;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch and serial shifter; pure datapath, no reset needed since
    // nothing here is observed before it is loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r  <= bus.operation;
            shreg <= bus.src_a;
            count <= shamt;
        end else if (state == SHIFT) begin
            shreg <= shift_nxt;
            count <= count - SHW'(1);
        end
    end

    // Result and zero flag. Zero is dropped when the result is taken so it
    // reads 0 whenever out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= '0;
            zero_r   <= 1'b0;
        end else if (accept && !go_shift) begin
            result_r <= alu_now;
            zero_r   <= (alu_now == '0);
        end else if (finish_shift) begin
            result_r <= shift_nxt;
            zero_r   <= (shift_nxt == '0);
        end else if (release_out) begin
            zero_r   <= 1'b0;
        end
    end

    assign bus.in_ready  = armed && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed testbench for alu_iterative: reset behaviour, each op class,
// serial-shift latency, back-pressure and zero-shift handling.
module tb_alu_iterative;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   lat;

    alu_iterative_if #(.WIDTH(32)) bus ();

    alu_iterative #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op, wait for acceptance, then count cycles to out_valid.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int latency);
        int guard;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.src_a     = a;
        bus.src_b     = b;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        latency = 1;
        while (!bus.out_valid && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    // Accept the current result for one edge.
    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operation = 4'b0000;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_post_edge", 32'(bus.in_ready), 32'd1);

        // ADD wrap to zero.
        send(4'b0010, 32'hFFFF_FFFF, 32'd1, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_result", bus.result, 32'd0);
        check("add_zero", 32'(bus.zero), 32'd1);
        check("add_in_ready_done", 32'(bus.in_ready), 32'd0);
        take();
        check("add_taken_valid", 32'(bus.out_valid), 32'd0);
        check("add_taken_zero", 32'(bus.zero), 32'd0);
        check("add_taken_in_ready", 32'(bus.in_ready), 32'd1);

        // ADD signed overflow wraps.
        send(4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
        check("add_ovf_result", bus.result, 32'h8000_0000);
        take();

        // SRA / SRL by 31 of the MSB.
        send(4'b0111, 32'h8000_0000, 32'd31, lat);
        check("sra31_lat", 32'(lat), 32'd32);
        check("sra31_result", bus.result, 32'hFFFF_FFFF);
        check("sra31_zero", 32'(bus.zero), 32'd0);
        take();
        send(4'b0101, 32'h8000_0000, 32'd31, lat);
        check("srl31_lat", 32'(lat), 32'd32);
        check("srl31_result", bus.result, 32'd1);
        take();

        // Short shifts.
        send(4'b0100, 32'd1, 32'd4, lat);
        check("sll4_lat", 32'(lat), 32'd5);
        check("sll4_result", bus.result, 32'd16);
        take();
        send(4'b0111, 32'h4000_0000, 32'd2, lat);
        check("sra2_pos_result", bus.result, 32'h1000_0000);
        take();
        send(4'b0100, 32'h8000_0001, 32'd1, lat);
        check("sll1_lat", 32'(lat), 32'd2);
        check("sll1_result", bus.result, 32'h0000_0002);
        take();

        // Signed compare and equality.
        send(4'b1100, 32'hFFFF_FFFF, 32'd1, lat);
        check("slt_neg_result", bus.result, 32'd1);
        check("slt_neg_zero", 32'(bus.zero), 32'd0);
        take();
        send(4'b1100, 32'd1, 32'hFFFF_FFFF, lat);
        check("slt_pos_result", bus.result, 32'd0);
        check("slt_pos_zero", 32'(bus.zero), 32'd1);
        take();
        send(4'b1000, 32'd5, 32'd5, lat);
        check("eq_same_result", bus.result, 32'd1);
        check("eq_same_zero", 32'(bus.zero), 32'd0);
        take();
        send(4'b1000, 32'd5, 32'd6, lat);
        check("eq_diff_result", bus.result, 32'd0);
        take();

        // Unused opcode.
        send(4'b0011, 32'h1234_5678, 32'h1111_1111, lat);
        check("undef_lat", 32'(lat), 32'd1);
        check("undef_result", bus.result, 32'd0);
        check("undef_zero", 32'(bus.zero), 32'd1);
        take();

        // Back-pressure with a pending op upstream.
        send(4'b0001, 32'h0000_00F0, 32'h0000_000F, lat);
        check("or_result", bus.result, 32'h0000_00FF);
        bus.in_valid  = 1'b1;
        bus.operation = 4'b0000;
        bus.src_a     = 32'hFF00_FF00;
        bus.src_b     = 32'h0FF0_0FF0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_result", bus.result, 32'h0000_00FF);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("pending_and_valid", 32'(bus.out_valid), 32'd1);
        check("pending_and_result", bus.result, 32'h0F00_0F00);
        take();

        // Shift with shamt==0 (upper bits of src_b ignored).
        send(4'b0100, 32'h1234_5678, 32'h0000_0120, lat);
        check("sll0_lat", 32'(lat), 32'd1);
        check("sll0_result", bus.result, 32'h1234_5678);
        take();

        // Reset in the middle of a long shift.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.operation = 4'b0100;
        bus.src_a     = 32'd1;
        bus.src_b     = 32'd20;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_held_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rel_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_stale_result", 32'(seen), 32'd0);

        // Normal operation after the abort.
        send(4'b0010, 32'd2, 32'd3, lat);
        check("post_rst_add", bus.result, 32'd5);
        take();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
